// File: rtl/vga_text_writer.sv
// Character-terminal front end: turns an ASCII byte stream into 16-bit text VRAM
// cell writes, tracks the hardware cursor, performs line/screen clears and drives the blink clock.
module vga_text_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 60,
  parameter int          BLINK_DIV = 25000000,
  parameter logic [15:0] BLANK     = 16'h0020
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  ch_data,
  input  logic [7:0]  ch_attr,
  input  logic        clr_req,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic [12:0] cursor,
  output logic        blink,
  output logic        busy
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, LINECLR, CLEAR} state_t;

  state_t          state_q;
  logic [5:0]      row_q;
  logic [6:0]      col_q;
  logic [6:0]      lineCol_q;
  logic            nlPend_q;
  logic            vramWe_q;
  logic [12:0]     vramAddr_q;
  logic [15:0]     vramWdata_q;
  logic [BW-1:0]   blinkCnt_q;
  logic            blink_q;

  logic [5:0]      nextRow_d;
  logic            startClr_d;
  logic            printable_d;

  // row*80+col without a multiplier: row*64 + row*16 + col
  function automatic logic [12:0] cellAddr(input logic [5:0] r, input logic [6:0] c);
    logic [12:0] r13;
    r13 = {7'd0, r};
    return (r13 << 6) + (r13 << 4) + {6'd0, c};
  endfunction

  always_comb begin
    nextRow_d   = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;
    startClr_d  = clr_req | (ch_valid & (ch_data == 8'h0C));
    printable_d = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
  end

  assign ch_ready   = (state_q == IDLE) & ~clr_req;
  assign busy       = (state_q != IDLE);
  assign cursor     = {row_q, col_q};
  assign vram_we    = vramWe_q;
  assign vram_addr  = vramAddr_q;
  assign vram_wdata = vramWdata_q;
  assign blink      = blink_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      lineCol_q   <= '0;
      nlPend_q    <= 1'b0;
      vramWe_q    <= 1'b0;
      vramAddr_q  <= '0;
      vramWdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          vramWe_q <= 1'b0;
          if (startClr_d) begin
            state_q     <= CLEAR;
            row_q       <= '0;
            col_q       <= '0;
            vramWe_q    <= 1'b1;
            vramAddr_q  <= '0;
            vramWdata_q <= BLANK;
          end else if (ch_valid) begin
            if (printable_d) begin
              state_q     <= WRITE;
              vramWe_q    <= 1'b1;
              vramAddr_q  <= cellAddr(row_q, col_q);
              vramWdata_q <= {ch_attr, 1'b0, ch_data[6:0]};
              // Last column: cursor jumps to the next row now, the row clear follows the write
              if (col_q == 7'(COLS - 1)) begin
                col_q    <= '0;
                row_q    <= nextRow_d;
                nlPend_q <= 1'b1;
              end else begin
                col_q    <= col_q + 7'd1;
                nlPend_q <= 1'b0;
              end
            end else begin
              case (ch_data)
                8'h0A: begin
                  state_q     <= LINECLR;
                  col_q       <= '0;
                  row_q       <= nextRow_d;
                  lineCol_q   <= '0;
                  vramWe_q    <= 1'b1;
                  vramAddr_q  <= cellAddr(nextRow_d, 7'd0);
                  vramWdata_q <= BLANK;
                end
                8'h0D: col_q <= '0;
                8'h08: begin
                  if (col_q != 7'd0) begin
                    state_q     <= WRITE;
                    col_q       <= col_q - 7'd1;
                    nlPend_q    <= 1'b0;
                    vramWe_q    <= 1'b1;
                    vramAddr_q  <= cellAddr(row_q, col_q - 7'd1);
                    vramWdata_q <= BLANK;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          if (nlPend_q) begin
            state_q     <= LINECLR;
            nlPend_q    <= 1'b0;
            lineCol_q   <= '0;
            vramWe_q    <= 1'b1;
            vramAddr_q  <= cellAddr(row_q, 7'd0);
            vramWdata_q <= BLANK;
          end else begin
            state_q  <= IDLE;
            vramWe_q <= 1'b0;
          end
        end
        LINECLR: begin
          if (lineCol_q == 7'(COLS - 1)) begin
            state_q  <= IDLE;
            vramWe_q <= 1'b0;
          end else begin
            lineCol_q  <= lineCol_q + 7'd1;
            vramAddr_q <= vramAddr_q + 13'd1;
          end
        end
        CLEAR: begin
          if (vramAddr_q == 13'(COLS * ROWS - 1)) begin
            state_q  <= IDLE;
            vramWe_q <= 1'b0;
          end else begin
            vramAddr_q <= vramAddr_q + 13'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          vramWe_q <= 1'b0;
        end
      endcase
    end
  end

  // Blink runs on its own counter so cursor flashing never stalls behind a clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      blinkCnt_q <= '0;
      blink_q    <= 1'b0;
    end else if (blinkCnt_q == BW'(BLINK_DIV - 1)) begin
      blinkCnt_q <= '0;
      blink_q    <= ~blink_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: the driver queues expected VRAM writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        chValid = 1'b0;
  logic [7:0]  chData = 8'h00;
  logic [7:0]  chAttr = 8'h00;
  logic        clrReq = 1'b0;
  logic        ch_ready, vram_we, blink, busy;
  logic [12:0] vram_addr, cursor;
  logic [15:0] vram_wdata;

  logic [28:0] expQ[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  vga_text_writer #(.COLS(80), .ROWS(60), .BLINK_DIV(4), .BLANK(16'h0020)) dut (
    .clk(clk), .rstn(rstn), .ch_valid(chValid), .ch_ready(ch_ready),
    .ch_data(chData), .ch_attr(chAttr), .clr_req(clrReq),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .cursor(cursor), .blink(blink), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [12:0] addr, input logic [15:0] data);
    expQ.push_back({addr, data});
  endtask

  task automatic expectLine(input int row);
    for (int c = 0; c < 80; c++) expectWrite(13'(row * 80 + c), 16'h0020);
  endtask

  task automatic expectRange(input int first, input int last);
    for (int a = first; a <= last; a++) expectWrite(13'(a), 16'h0020);
  endtask

  // Offer one byte, return at the negedge following the accepting edge
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] attr);
    int n = 0;
    while (!ch_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) checkOutput("readyTimeout", ch_ready, 1);
    chValid = 1'b1;
    chData  = data;
    chAttr  = attr;
    @(posedge clk);
    #1 chValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("drainInTime", 32'(n < limit), 1);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 6000) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && vram_we === 1'b1) begin
      checkOutput("busyDuringWrite", 32'(busy), 1);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWrite: got addr %0d data 0x%0h, expected no write", vram_addr, vram_wdata);
      end else begin
        checkOutput("vramWrite", {3'b0, vram_addr, vram_wdata}, {3'b0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    // Reset values and blink cadence
    repeat (3) @(negedge clk);
    checkOutput("rstCursor", 32'(cursor), 0);
    checkOutput("rstWe", 32'(vram_we), 0);
    checkOutput("rstAddr", 32'(vram_addr), 0);
    checkOutput("rstWdata", 32'(vram_wdata), 0);
    checkOutput("rstBlink", 32'(blink), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    rstn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("readyAfterRst", 32'(ch_ready), 1);
      if (i == 3) checkOutput("blinkEdge3", 32'(blink), 0);
      if (i == 4) checkOutput("blinkEdge4", 32'(blink), 1);
      if (i == 7) checkOutput("blinkEdge7", 32'(blink), 1);
      if (i == 8) checkOutput("blinkEdge8", 32'(blink), 0);
    end

    // Single printable byte
    expectWrite(13'd0, 16'h0F41);
    applyStimulus(8'h41, 8'h0F);
    checkOutput("readyLowAfterA", 32'(ch_ready), 0);
    checkOutput("cursorAfterA", 32'(cursor), 32'h1);
    @(negedge clk);
    checkOutput("readyBackAfterA", 32'(ch_ready), 1);

    // clr_req beats ch_valid; byte taken after the clear
    expectRange(0, 4799);
    expectWrite(13'd0, 16'h075A);
    clrReq  = 1'b1;
    chValid = 1'b1;
    chData  = 8'h5A;
    chAttr  = 8'h07;
    #1 checkOutput("readyDuringClrReq", 32'(ch_ready), 0);
    @(posedge clk);
    #1 clrReq = 1'b0;
    @(negedge clk);
    checkOutput("cursorAtClear", 32'(cursor), 0);
    countBusy(n);
    checkOutput("clearBusyCycles", 32'(n), 4800);
    @(posedge clk);
    #1 chValid = 1'b0;
    waitIdle(100);
    checkOutput("cursorAfterZ", 32'(cursor), 32'h1);

    // Form feed clear, then a full row of text and the implied row clear
    expectRange(0, 4799);
    applyStimulus(8'h0C, 8'h00);
    waitIdle(6000);
    for (int i = 0; i < 80; i++) begin
      expectWrite(13'(i), 16'h1E21 + 16'(i));
      if (i == 79) expectLine(1);
      applyStimulus(8'h21 + 8'(i), 8'h1E);
    end
    waitIdle(200);
    checkOutput("cursorAfterRow", 32'(cursor), 32'h080);

    // Walk down to row 59 col 5, then LF wraps to row 0
    for (int r = 2; r < 60; r++) begin
      expectLine(r);
      applyStimulus(8'h0A, 8'h00);
    end
    for (int c = 0; c < 5; c++) begin
      expectWrite(13'(4720 + c), 16'h7061 + 16'(c));
      applyStimulus(8'h61 + 8'(c), 8'h70);
    end
    waitIdle(100);
    checkOutput("cursorRow59Col5", 32'(cursor), 32'h1D85);
    expectLine(0);
    applyStimulus(8'h0A, 8'h00);
    countBusy(n);
    checkOutput("lfBusyCycles", 32'(n), 80);
    checkOutput("cursorAfterWrap", 32'(cursor), 0);
    waitIdle(100);

    // Backspace, then backspace at col 0
    expectWrite(13'd0, 16'h2A42);
    applyStimulus(8'h42, 8'h2A);
    expectWrite(13'd0, 16'h0020);
    applyStimulus(8'h08, 8'h00);
    waitIdle(100);
    checkOutput("cursorAfterBs", 32'(cursor), 0);
    applyStimulus(8'h08, 8'h00);
    checkOutput("bsCol0Ready", 32'(ch_ready), 1);
    checkOutput("bsCol0Busy", 32'(busy), 0);
    checkOutput("bsCol0Cursor", 32'(cursor), 0);

    // CR and an ignored control byte
    expectWrite(13'd0, 16'h0778);
    applyStimulus(8'h78, 8'h07);
    expectWrite(13'd1, 16'h0779);
    applyStimulus(8'h79, 8'h07);
    waitIdle(100);
    checkOutput("cursorBeforeCr", 32'(cursor), 32'h2);
    applyStimulus(8'h0D, 8'h00);
    checkOutput("cursorAfterCr", 32'(cursor), 0);
    checkOutput("readyAfterCr", 32'(ch_ready), 1);
    expectWrite(13'd0, 16'h0531);
    applyStimulus(8'h31, 8'h05);
    waitIdle(100);
    applyStimulus(8'h01, 8'h00);
    checkOutput("cursorAfterIgnored", 32'(cursor), 32'h1);
    checkOutput("busyAfterIgnored", 32'(busy), 0);

    // Reset in the middle of a screen clear
    expectRange(0, 100);
    applyStimulus(8'h0C, 8'h00);
    n = 0;
    while (expQ.size() != 0 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("clearReached100", 32'(vram_addr), 100);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midRstWe", 32'(vram_we), 0);
    checkOutput("midRstCursor", 32'(cursor), 0);
    checkOutput("midRstBlink", 32'(blink), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("noWritesAfterRst", 32'(busy), 0);
    checkOutput("queueEmpty", 32'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
